// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder_if
// Description : SPI pin bundle and single-port memory port for the flash
//               responder. The slave side is the responder; the master side
//               is the SPI initiator together with the backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
) ();
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_cs;
  logic              spi_miso;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              busy;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs, mem_rdata,
    output spi_miso, mem_addr, mem_rd, mem_we, mem_wdata, busy
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs, mem_rdata,
    input  spi_miso, mem_addr, mem_rd, mem_we, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : SPI mode-0 target emulating a serial NOR flash on top of a
//               synchronous single-port memory. Serves RDSR, RDID, WREN,
//               WRDI, READ, FAST READ, page program and 32K block erase.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter int          ERASE_SIZE = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_flash_responder_if.slave  bus
);

  localparam int              EW         = (ERASE_SIZE > 1) ? $clog2(ERASE_SIZE) : 1;
  localparam logic [ADDR_W-1:0] ERASE_MASK = ADDR_W'(ERASE_SIZE - 1);
  localparam logic [EW-1:0]   ERASE_LAST = EW'(ERASE_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_STATUS  = 4'd1,
    S_RDID    = 4'd2,
    S_ADDR    = 4'd3,
    S_DUMMY   = 4'd4,
    S_DATA    = 4'd5,
    S_PDATA   = 4'd6,
    S_WAIT_CS = 4'd7,
    S_SINK    = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    C_READ  = 2'd0,
    C_FAST  = 2'd1,
    C_PROG  = 2'd2,
    C_ERASE = 2'd3
  } cmd_t;

  state_t            state_q;
  cmd_t              cmd_q;
  logic              sck_q;
  logic              cs_q;
  logic [6:0]        rx_sr_q;
  logic [7:0]        tx_sr_q;
  logic [2:0]        bit_cnt_q;
  logic [1:0]        abyte_q;
  logic [1:0]        rdid_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              miso_q;
  logic              mem_rd_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              ld_q;
  logic              wel_q;
  logic              wip_q;
  logic              post_prog_q;
  logic              post_erase_q;
  logic [ADDR_W-1:0] erase_base_q;
  logic [EW-1:0]     erase_cnt_q;

  logic              rise_d;
  logic [7:0]        byte_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        status_d;

  // SCK rising edge qualified by chip select; the completed byte includes the bit sampled now
  assign rise_d   = bus.spi_sck & ~sck_q & ~bus.spi_cs;
  assign byte_d   = {rx_sr_q, bus.spi_mosi};
  assign addr_d   = ADDR_W'({addr_q, byte_d});
  assign status_d = {6'b0, wel_q, wip_q};

  assign bus.spi_miso  = miso_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = wip_q;

  // Bit engine, command FSM, memory port and erase loop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= C_READ;
      sck_q        <= 1'b0;
      cs_q         <= 1'b1;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      bit_cnt_q    <= '0;
      abyte_q      <= '0;
      rdid_idx_q   <= '0;
      addr_q       <= '0;
      miso_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ld_q         <= 1'b0;
      wel_q        <= 1'b0;
      wip_q        <= 1'b0;
      post_prog_q  <= 1'b0;
      post_erase_q <= 1'b0;
      erase_base_q <= '0;
      erase_cnt_q  <= '0;
    end else begin
      sck_q    <= bus.spi_sck;
      cs_q     <= bus.spi_cs;
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      ld_q     <= mem_rd_q;

      // Read data arrives one clk after the strobe; the inter-byte gap guarantees
      // this lands before the next SCK rise
      if (ld_q) begin
        tx_sr_q <= bus.mem_rdata;
        addr_q  <= addr_q + ADDR_W'(1);
      end

      // The erase loop owns the memory port and ignores CS activity
      if (wip_q) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= 8'hFF;
        mem_addr_q  <= erase_base_q | ADDR_W'(erase_cnt_q);
        erase_cnt_q <= erase_cnt_q + EW'(1);
        if (erase_cnt_q == ERASE_LAST) begin
          wip_q <= 1'b0;
          wel_q <= 1'b0;
        end
      end

      if (bus.spi_cs) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        tx_sr_q   <= '0;
        miso_q    <= 1'b0;
        ld_q      <= 1'b0;
        if (!cs_q) begin
          post_prog_q  <= 1'b0;
          post_erase_q <= 1'b0;
          if (post_prog_q) begin
            wel_q <= 1'b0;
          end
          if (post_erase_q) begin
            wip_q        <= 1'b1;
            erase_cnt_q  <= '0;
            erase_base_q <= addr_q & ~ERASE_MASK;
          end
        end
      end else if (rise_d) begin
        rx_sr_q   <= byte_d[6:0];
        tx_sr_q   <= {tx_sr_q[6:0], 1'b0};
        miso_q    <= tx_sr_q[7];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            S_IDLE: begin
              state_q <= S_SINK;
              if (byte_d == 8'h05) begin
                state_q <= S_STATUS;
                tx_sr_q <= status_d;
              end else if (!wip_q) begin
                case (byte_d)
                  8'h9F: begin
                    state_q    <= S_RDID;
                    tx_sr_q    <= JEDEC_ID[23:16];
                    rdid_idx_q <= 2'd1;
                  end
                  8'h06: wel_q <= 1'b1;
                  8'h04: wel_q <= 1'b0;
                  8'h03: begin
                    state_q <= S_ADDR;
                    cmd_q   <= C_READ;
                    abyte_q <= '0;
                  end
                  8'h0B: begin
                    state_q <= S_ADDR;
                    cmd_q   <= C_FAST;
                    abyte_q <= '0;
                  end
                  8'h02: begin
                    if (wel_q) begin
                      state_q     <= S_ADDR;
                      cmd_q       <= C_PROG;
                      abyte_q     <= '0;
                      post_prog_q <= 1'b1;
                    end
                  end
                  8'h52: begin
                    if (wel_q) begin
                      state_q <= S_ADDR;
                      cmd_q   <= C_ERASE;
                      abyte_q <= '0;
                    end
                  end
                  default: ;
                endcase
              end
            end
            S_STATUS: tx_sr_q <= status_d;
            S_RDID: begin
              case (rdid_idx_q)
                2'd1:    tx_sr_q <= JEDEC_ID[15:8];
                2'd2:    tx_sr_q <= JEDEC_ID[7:0];
                default: tx_sr_q <= 8'h00;
              endcase
              if (rdid_idx_q != 2'd3) begin
                rdid_idx_q <= rdid_idx_q + 2'd1;
              end
            end
            S_ADDR: begin
              addr_q  <= addr_d;
              abyte_q <= abyte_q + 2'd1;
              if (abyte_q == 2'd2) begin
                case (cmd_q)
                  C_READ: begin
                    state_q    <= S_DATA;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= addr_d;
                  end
                  C_FAST:  state_q <= S_DUMMY;
                  C_PROG:  state_q <= S_PDATA;
                  default: begin
                    state_q      <= S_WAIT_CS;
                    post_erase_q <= 1'b1;
                  end
                endcase
              end
            end
            S_DUMMY, S_DATA: begin
              state_q    <= S_DATA;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= addr_q;
            end
            S_PDATA: begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= byte_d;
              mem_addr_q  <= addr_q;
              addr_q      <= {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
            end
            default: tx_sr_q <= 8'h00;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_responder
// Description : Scoreboard bench for spi_flash_responder. Drives SPI at
//               clk/2, models the backing memory, and compares MISO bytes,
//               read strobes and write strobes against queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  mem [0:65535];
  bit          mem_init = 1'b0;
  bit          erase_free = 1'b0;
  int          busy_run = 0;
  int          busy_len = 0;
  logic [7:0]  exp_miso [$];
  logic [15:0] exp_rd [$];
  logic [23:0] exp_we [$];
  logic [15:0] e_rd;
  logic [23:0] e_we;

  spi_flash_responder_if #(.ADDR_W(AW)) bus ();

  spi_flash_responder #(
    .ADDR_W(AW), .JEDEC_ID(24'hEF4016), .ERASE_SIZE(32768)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory: synchronous read, one-clk latency
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0100] = 8'hA5;
      mem[16'h0101] = 8'h3C;
      mem_init = 1'b1;
    end else begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Memory-port scoreboard and busy run-length tracking
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd || bus.mem_we) chk("rd_we_exclusive", 32'(bus.mem_rd & bus.mem_we), 0);
      if (bus.mem_rd) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          e_rd = exp_rd.pop_front();
          chk("rd_addr", 32'(bus.mem_addr), 32'(e_rd));
        end
      end
      if (bus.mem_we) begin
        if (erase_free) begin
          chk("erase2_wr", {23'b0, bus.mem_addr < 16'h8000, bus.mem_wdata}, {23'b0, 1'b1, 8'hFF});
        end else begin
          chk("we_expected", 32'(exp_we.size() != 0), 1);
          if (exp_we.size() != 0) begin
            e_we = exp_we.pop_front();
            chk("we_addr_data", {8'b0, bus.mem_addr, bus.mem_wdata}, {8'b0, e_we});
          end
        end
      end
    end
    if (bus.busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input logic [7:0] exp,
                          input bit do_chk, input string tag);
    logic [7:0] rx;
    logic [7:0] e;
    rx = 8'h00;
    if (do_chk) exp_miso.push_back(exp);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.spi_mosi = tx[7-i];
      bus.spi_sck  = 1'b1;
      @(negedge clk);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    if (do_chk) begin
      e = exp_miso.pop_front();
      chk(tag, 32'(rx), 32'(e));
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string tag);
    int n;
    n = 0;
    while (bus.busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.busy), 32'(lvl));
  endtask

  task automatic rdsr(input logic [7:0] exp, input string tag);
    cs_low();
    spi_xfer(8'h05, 8, 8'h00, 1, "rdsr_op");
    spi_xfer(8'h00, 8, exp, 1, tag);
    cs_high();
  endtask

  task automatic wren();
    cs_low();
    spi_xfer(8'h06, 8, 8'h00, 1, "wren_op");
    cs_high();
  endtask

  initial begin
    bus.spi_sck   = 1'b0;
    bus.spi_mosi  = 1'b0;
    bus.spi_cs    = 1'b1;
    bus.mem_rdata = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_miso",  32'(bus.spi_miso), 0);
    chk("rst_rd",    32'(bus.mem_rd), 0);
    chk("rst_we",    32'(bus.mem_we), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fast read of two bytes at 0x000100
    cs_low();
    spi_xfer(8'h0B, 8, 8'h00, 1, "fast_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_a0");
    spi_xfer(8'h01, 8, 8'h00, 1, "fast_a1");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_a2");
    exp_rd.push_back(16'h0100);
    spi_xfer(8'hFF, 8, 8'h00, 1, "fast_dummy");
    exp_rd.push_back(16'h0101);
    spi_xfer(8'h00, 8, 8'hA5, 1, "fast_d0");
    exp_rd.push_back(16'h0102);
    spi_xfer(8'h00, 8, 8'h3C, 1, "fast_d1");
    cs_high();
    chk("fast_rd_left", 32'(exp_rd.size()), 0);

    // JEDEC ID followed by zero fill, then idle status
    cs_low();
    spi_xfer(8'h9F, 8, 8'h00, 1, "rdid_op");
    spi_xfer(8'h00, 8, 8'hEF, 1, "rdid_b0");
    spi_xfer(8'h00, 8, 8'h40, 1, "rdid_b1");
    spi_xfer(8'h00, 8, 8'h16, 1, "rdid_b2");
    spi_xfer(8'h00, 8, 8'h00, 1, "rdid_b3");
    cs_high();
    rdsr(8'h00, "rdsr_idle");

    // Program without WREN is ignored
    cs_low();
    spi_xfer(8'h02, 8, 8'h00, 1, "prog_nowel_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "prog_nowel_a0");
    spi_xfer(8'h00, 8, 8'h00, 1, "prog_nowel_a1");
    spi_xfer(8'h10, 8, 8'h00, 1, "prog_nowel_a2");
    spi_xfer(8'h55, 8, 8'h00, 1, "prog_nowel_d");
    cs_high();
    wren();
    rdsr(8'h02, "rdsr_wel");

    // Page program wrapping inside the page
    cs_low();
    spi_xfer(8'h02, 8, 8'h00, 1, "prog_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "prog_a0");
    spi_xfer(8'h00, 8, 8'h00, 1, "prog_a1");
    spi_xfer(8'hFE, 8, 8'h00, 1, "prog_a2");
    exp_we.push_back({16'h00FE, 8'h11});
    exp_we.push_back({16'h00FF, 8'h22});
    exp_we.push_back({16'h0000, 8'h33});
    spi_xfer(8'h11, 8, 8'h00, 1, "prog_d0");
    spi_xfer(8'h22, 8, 8'h00, 1, "prog_d1");
    spi_xfer(8'h33, 8, 8'h00, 1, "prog_d2");
    cs_high();
    chk("prog_we_left", 32'(exp_we.size()), 0);
    rdsr(8'h00, "rdsr_after_prog");

    // Block erase of the aligned 32K block containing 0x00ABCD
    wren();
    cs_low();
    spi_xfer(8'h52, 8, 8'h00, 1, "erase_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "erase_a0");
    spi_xfer(8'hAB, 8, 8'h00, 1, "erase_a1");
    spi_xfer(8'hCD, 8, 8'h00, 1, "erase_a2");
    for (int i = 0; i < 32768; i++) exp_we.push_back({16'(16'h8000 + i), 8'hFF});
    cs_high();
    wait_busy(1'b1, 10, "erase_busy_rise");
    rdsr(8'h03, "rdsr_mid_erase");
    cs_low();
    spi_xfer(8'h0B, 8, 8'h00, 1, "fast_busy_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_busy_a0");
    spi_xfer(8'h01, 8, 8'h00, 1, "fast_busy_a1");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_busy_a2");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_busy_dummy");
    spi_xfer(8'h00, 8, 8'h00, 1, "fast_busy_d0");
    cs_high();
    wait_busy(1'b0, 40000, "erase_busy_fall");
    @(negedge clk);
    chk("erase_busy_len", 32'(busy_len), 32768);
    chk("erase_we_left", 32'(exp_we.size()), 0);
    rdsr(8'h00, "rdsr_after_erase");

    // Aborted opcode, then a full RDID
    cs_low();
    spi_xfer(8'h9F, 5, 8'h00, 0, "partial");
    cs_high();
    cs_low();
    spi_xfer(8'h9F, 8, 8'h00, 1, "rdid2_op");
    spi_xfer(8'h00, 8, 8'hEF, 1, "rdid2_b0");
    cs_high();

    // Unknown opcode sinks everything
    cs_low();
    spi_xfer(8'hAB, 8, 8'h00, 1, "unk_op");
    spi_xfer(8'hFF, 8, 8'h00, 1, "unk_b0");
    spi_xfer(8'h5A, 8, 8'h00, 1, "unk_b1");
    cs_high();

    // Reset in the middle of an erase
    wren();
    cs_low();
    spi_xfer(8'h52, 8, 8'h00, 1, "erase2_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "erase2_a0");
    spi_xfer(8'h00, 8, 8'h00, 1, "erase2_a1");
    spi_xfer(8'h00, 8, 8'h00, 1, "erase2_a2");
    erase_free = 1'b1;
    cs_high();
    wait_busy(1'b1, 10, "erase2_busy_rise");
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    erase_free = 1'b0;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("erase2_rst_busy", 32'(bus.busy), 0);
    rdsr(8'h00, "rdsr_after_erase_rst");

    // Reset in the middle of a read
    cs_low();
    spi_xfer(8'h03, 8, 8'h00, 1, "read_op");
    spi_xfer(8'h00, 8, 8'h00, 1, "read_a0");
    spi_xfer(8'h01, 8, 8'h00, 1, "read_a1");
    exp_rd.push_back(16'h0100);
    spi_xfer(8'h00, 8, 8'h00, 1, "read_a2");
    exp_rd.push_back(16'h0101);
    spi_xfer(8'h00, 8, 8'hA5, 1, "read_d0");
    chk("read_miso_before_rst", 32'(bus.spi_miso), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("read_rst_miso", 32'(bus.spi_miso), 0);
    chk("read_rst_busy", 32'(bus.busy), 0);
    cs_high();
    rdsr(8'h00, "rdsr_after_read_rst");
    chk("final_rd_left", 32'(exp_rd.size()), 0);
    chk("final_we_left", 32'(exp_we.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
